// File: rtl/note_player.sv
// Playback sequencer: walks the composition array, sounding each note as a square wave
// for a fixed duration followed by a silent gap.
module note_player #(
    parameter int DEPTH       = 40,
    parameter int NOTE_TICKS  = 12500000,
    parameter int GAP_TICKS   = 1250000,
    parameter int PITCH_SHIFT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play,
    input  logic       stop,
    input  logic       loop_en,
    input  logic [5:0] i_note,
    input  logic [5:0] note_in,
    output logic [5:0] rd_addr,
    output logic [5:0] cur_pos,
    output logic       tone_out,
    output logic       playing,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

    localparam logic [31:0] NOTE_LAST   = 32'(NOTE_TICKS - 1);
    localparam logic [31:0] GAP_LAST    = (GAP_TICKS > 0) ? 32'(GAP_TICKS - 1) : 32'd0;
    localparam logic [5:0]  DEPTH_CLAMP = 6'(DEPTH);

    // Octave-3 half-periods at 50 MHz; higher octaves are right shifts of these.
    function automatic logic [17:0] half_period_of(input logic [5:0] code);
        logic [5:0]  idx;
        logic [3:0]  semi;
        logic [2:0]  oct;
        logic [17:0] base;
        idx  = code - 6'd1;
        semi = 4'(idx % 6'd12);
        oct  = 3'(idx / 6'd12);
        case (semi)
            4'd0:    base = 18'd191113;
            4'd1:    base = 18'd180388;
            4'd2:    base = 18'd170265;
            4'd3:    base = 18'd160705;
            4'd4:    base = 18'd151685;
            4'd5:    base = 18'd143172;
            4'd6:    base = 18'd135139;
            4'd7:    base = 18'd127551;
            4'd8:    base = 18'd120395;
            4'd9:    base = 18'd113636;
            4'd10:   base = 18'd107259;
            default: base = 18'd101239;
        endcase
        return base >> (32'(oct) + 32'(PITCH_SHIFT));
    endfunction

    state_t      state, state_nxt;
    logic [5:0]  addr_nxt, cur_pos_nxt;
    logic [5:0]  note_reg, note_nxt;
    logic [17:0] half_period, half_nxt;
    logic [17:0] tone_cnt, tone_cnt_nxt;
    logic [31:0] dur_cnt, dur_nxt;
    logic        tone_nxt, done_nxt;
    logic        end_note;
    logic [5:0]  n_live;
    logic        note_rest;

    assign n_live    = (i_note > DEPTH_CLAMP) ? DEPTH_CLAMP : i_note;
    assign note_rest = (note_reg == 6'd0) || (note_reg > 6'd48);
    assign playing   = (state != IDLE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_nxt    = state;
        addr_nxt     = rd_addr;
        cur_pos_nxt  = cur_pos;
        note_nxt     = note_reg;
        half_nxt     = half_period;
        tone_cnt_nxt = tone_cnt;
        dur_nxt      = dur_cnt;
        tone_nxt     = tone_out;
        done_nxt     = 1'b0;
        end_note     = 1'b0;

        case (state)
            IDLE: begin
                if (play && (n_live != 6'd0)) begin
                    state_nxt = FETCH;
                    addr_nxt  = 6'd0;
                end
            end
            FETCH: begin
                note_nxt     = note_in;
                half_nxt     = half_period_of(note_in);
                cur_pos_nxt  = rd_addr;
                tone_cnt_nxt = 18'd0;
                dur_nxt      = 32'd0;
                tone_nxt     = 1'b0;
                state_nxt    = PLAY;
            end
            PLAY: begin
                if (note_rest) begin
                    tone_nxt = 1'b0;
                end else if ({1'b0, tone_cnt} + 19'd1 >= {1'b0, half_period}) begin
                    tone_nxt     = ~tone_out;
                    tone_cnt_nxt = 18'd0;
                end else begin
                    tone_cnt_nxt = tone_cnt + 18'd1;
                end
                if (dur_cnt == NOTE_LAST) begin
                    tone_nxt = 1'b0;
                    dur_nxt  = 32'd0;
                    if (GAP_TICKS == 0) end_note = 1'b1;
                    else                state_nxt = GAP;
                end else begin
                    dur_nxt = dur_cnt + 32'd1;
                end
            end
            GAP: begin
                tone_nxt = 1'b0;
                if (dur_cnt == GAP_LAST) begin
                    dur_nxt  = 32'd0;
                    end_note = 1'b1;
                end else begin
                    dur_nxt = dur_cnt + 32'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Note count is re-read here so a shortened composition ends after the current note.
        if (end_note) begin
            if ({1'b0, rd_addr} + 7'd1 < {1'b0, n_live}) begin
                state_nxt = FETCH;
                addr_nxt  = rd_addr + 6'd1;
            end else if (loop_en) begin
                state_nxt = FETCH;
                addr_nxt  = 6'd0;
            end else begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
        end

        if (stop) begin
            state_nxt = IDLE;
            tone_nxt  = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; the comb block uses blocking.
        if (reset) begin
            state       <= IDLE;
            rd_addr     <= 6'd0;
            cur_pos     <= 6'd0;
            note_reg    <= 6'd0;
            half_period <= 18'd0;
            tone_cnt    <= 18'd0;
            dur_cnt     <= 32'd0;
            tone_out    <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            rd_addr     <= addr_nxt;
            cur_pos     <= cur_pos_nxt;
            note_reg    <= note_nxt;
            half_period <= half_nxt;
            tone_cnt    <= tone_cnt_nxt;
            dur_cnt     <= dur_nxt;
            tone_out    <= tone_nxt;
            done        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: expected output events are queued when a playback is
// started and matched against observed changes on rd_addr, cur_pos, tone_out and done.
module tb_note_player;

    localparam int NT = 100;
    localparam int GT = 10;
    localparam int PS = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       play = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [5:0] i_note = 6'd0;
    logic [5:0] note_in, rd_addr, cur_pos;
    logic       tone_out, playing, done;
    logic [5:0] ram [64];

    logic       play_b = 1'b0, stop_b = 1'b0, loop_en_b = 1'b0;
    logic [5:0] i_note_b = 6'd0;
    logic [5:0] note_in_b, rd_addr_b, cur_pos_b;
    logic       tone_out_b, playing_b, done_b;
    logic [5:0] ram_b [64];

    always #5 clk = ~clk;

    assign note_in   = ram[rd_addr];
    assign note_in_b = ram_b[rd_addr_b];

    note_player #(.DEPTH(40), .NOTE_TICKS(NT), .GAP_TICKS(GT), .PITCH_SHIFT(PS)) dut (
        .clk(clk), .reset(reset), .play(play), .stop(stop), .loop_en(loop_en),
        .i_note(i_note), .note_in(note_in), .rd_addr(rd_addr), .cur_pos(cur_pos),
        .tone_out(tone_out), .playing(playing), .done(done)
    );

    note_player #(.DEPTH(40), .NOTE_TICKS(NT), .GAP_TICKS(0), .PITCH_SHIFT(PS)) dut_b (
        .clk(clk), .reset(reset), .play(play_b), .stop(stop_b), .loop_en(loop_en_b),
        .i_note(i_note_b), .note_in(note_in_b), .rd_addr(rd_addr_b), .cur_pos(cur_pos_b),
        .tone_out(tone_out_b), .playing(playing_b), .done(done_b)
    );

    typedef enum {EV_ADDR, EV_CUR, EV_TONE, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       edge_no;
        int       value;
    } ev_t;

    ev_t exp_q[$];
    int  edge_no;
    int  compared = 0;
    int  mismatched = 0;

    function automatic void push_ev(input ev_kind_t k, input int e, input int v);
        ev_t ev;
        ev.kind    = k;
        ev.edge_no = e;
        ev.value   = v;
        exp_q.push_back(ev);
    endfunction

    // Note starting at edge 'base' (FETCH entry): PLAY's cycle j has tone_cnt=j-1, so the
    // m-th toggle lands on edge base+1+m*hp while inside PLAY; exit forces tone_out low.
    function automatic void push_tone(input int base, input int hp);
        int v = 0;
        for (int m = 1; 1 + m * hp <= NT; m++) begin
            v ^= 1;
            push_ev(EV_TONE, base + 1 + m * hp, v);
        end
        if (v == 1) push_ev(EV_TONE, base + NT + 1, 0);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic start_play();
        play = 1'b1;
        @(posedge clk); #1;
        play = 1'b0;
        edge_no = 0;
    endtask

    task automatic watch(input int cycles);
        logic [5:0] p_addr, p_cur;
        logic       p_tone, p_done;
        ev_t        seen[$];
        ev_t        ev, ex;
        p_addr = rd_addr; p_cur = cur_pos; p_tone = tone_out; p_done = done;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            edge_no++;
            seen.delete();
            if (rd_addr !== p_addr) begin
                ev.kind = EV_ADDR; ev.edge_no = edge_no; ev.value = int'(rd_addr); seen.push_back(ev);
            end
            if (cur_pos !== p_cur) begin
                ev.kind = EV_CUR; ev.edge_no = edge_no; ev.value = int'(cur_pos); seen.push_back(ev);
            end
            if (tone_out !== p_tone) begin
                ev.kind = EV_TONE; ev.edge_no = edge_no; ev.value = int'(tone_out); seen.push_back(ev);
            end
            if (done === 1'b1 && p_done !== 1'b1) begin
                ev.kind = EV_DONE; ev.edge_no = edge_no; ev.value = 1; seen.push_back(ev);
                compared++;
                if (playing !== 1'b0) begin
                    mismatched++;
                    $display("FAIL done_playing: playing=%b with done, required 0", playing);
                end
            end
            foreach (seen[k]) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_event: %s=%0d at edge %0d, required no change",
                             seen[k].kind.name(), seen[k].value, seen[k].edge_no);
                end else begin
                    ex = exp_q.pop_front();
                    if (seen[k].kind != ex.kind || seen[k].edge_no != ex.edge_no ||
                        seen[k].value != ex.value) begin
                        mismatched++;
                        $display("FAIL event: got %s=%0d at edge %0d, required %s=%0d at edge %0d",
                                 seen[k].kind.name(), seen[k].value, seen[k].edge_no,
                                 ex.kind.name(), ex.value, ex.edge_no);
                    end
                end
            end
            p_addr = rd_addr; p_cur = cur_pos; p_tone = tone_out; p_done = done;
        end
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL missing_event: %s=%0d at edge %0d never observed",
                     ex.kind.name(), ex.value, ex.edge_no);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        compared++;
        if ({rd_addr, cur_pos, tone_out, playing, done} !== 15'd0) begin
            mismatched++;
            $display("FAIL reset_a: addr=%0d cur=%0d tone=%b playing=%b done=%b, required all 0",
                     rd_addr, cur_pos, tone_out, playing, done);
        end
        compared++;
        if ({rd_addr_b, cur_pos_b, tone_out_b, playing_b, done_b} !== 15'd0) begin
            mismatched++;
            $display("FAIL reset_b: addr=%0d cur=%0d tone=%b playing=%b done=%b, required all 0",
                     rd_addr_b, cur_pos_b, tone_out_b, playing_b, done_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequence();
        do_reset();
        ram[0] = 6'd10; ram[1] = 6'd0; ram[2] = 6'd22;
        i_note = 6'd3; loop_en = 1'b0;
        push_tone(0, 27);
        push_ev(EV_ADDR, 111, 1);
        push_ev(EV_CUR, 112, 1);
        push_ev(EV_ADDR, 222, 2);
        push_ev(EV_CUR, 223, 2);
        push_tone(222, 13);
        push_ev(EV_DONE, 333, 1);
        start_play();
        compared++;
        if (playing !== 1'b1) begin
            mismatched++;
            $display("FAIL seq_playing: playing=%b after play, required 1", playing);
        end
        watch(345);
        compared++;
        if (playing !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL seq_idle: playing=%b done=%b, required 0/0", playing, done);
        end
    endtask

    task automatic test_zero_notes();
        do_reset();
        i_note = 6'd0;
        play = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            compared++;
            if (playing !== 1'b0 || done !== 1'b0 || tone_out !== 1'b0) begin
                mismatched++;
                $display("FAIL zero_notes: playing=%b done=%b tone=%b, required 0/0/0",
                         playing, done, tone_out);
            end
        end
        play = 1'b0;
    endtask

    task automatic test_lower_inote();
        do_reset();
        ram[0] = 6'd10; ram[1] = 6'd0; ram[2] = 6'd22;
        i_note = 6'd3;
        push_tone(0, 27);
        push_ev(EV_DONE, 111, 1);
        start_play();
        i_note = 6'd1;
        watch(120);
    endtask

    task automatic test_loop_stop();
        do_reset();
        ram[0] = 6'd1; ram[1] = 6'd1;
        i_note = 6'd2; loop_en = 1'b1;
        push_tone(0, 46);
        push_ev(EV_ADDR, 111, 1);
        push_ev(EV_CUR, 112, 1);
        push_tone(111, 46);
        push_ev(EV_ADDR, 222, 0);
        push_ev(EV_CUR, 223, 0);
        push_tone(222, 46);
        start_play();
        watch(324);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        loop_en = 1'b0;
        compared++;
        if (playing !== 1'b0 || done !== 1'b0 || tone_out !== 1'b0) begin
            mismatched++;
            $display("FAIL stop_gap: playing=%b done=%b tone=%b, required 0/0/0",
                     playing, done, tone_out);
        end
        watch(20);
    endtask

    task automatic test_play_stop();
        do_reset();
        i_note = 6'd2;
        play = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        play = 1'b0; stop = 1'b0;
        compared++;
        if (playing !== 1'b0) begin
            mismatched++;
            $display("FAIL play_stop: playing=%b, required 0", playing);
        end
        @(posedge clk); #1;
        compared++;
        if (playing !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL play_stop_hold: playing=%b done=%b, required 0/0", playing, done);
        end
    endtask

    task automatic test_reset_mid_play();
        do_reset();
        ram[0] = 6'd10; ram[1] = 6'd0; ram[2] = 6'd22;
        i_note = 6'd3;
        start_play();
        repeat (30) @(posedge clk);
        #1;
        compared++;
        if (tone_out !== 1'b1 || playing !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_play_pre: tone=%b playing=%b, required 1/1", tone_out, playing);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        compared++;
        if ({rd_addr, cur_pos, tone_out, playing, done} !== 15'd0) begin
            mismatched++;
            $display("FAIL mid_play_reset: addr=%0d cur=%0d tone=%b playing=%b done=%b, required 0",
                     rd_addr, cur_pos, tone_out, playing, done);
        end
        @(posedge clk); #1;
        compared++;
        if (playing !== 1'b0 || tone_out !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_play_idle: playing=%b tone=%b, required 0/0", playing, tone_out);
        end
    endtask

    // No-gap instance: a rest code sounds nothing, done lands one FETCH plus NT cycles later,
    // and a play level still high at done restarts on the next edge.
    task automatic test_no_gap_back_to_back();
        int tone_bad = 0;
        do_reset();
        ram_b[0] = 6'd63;
        i_note_b = 6'd1;
        play_b = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (playing_b !== 1'b1) begin
            mismatched++;
            $display("FAIL nogap_start: playing=%b, required 1", playing_b);
        end
        for (int e = 1; e <= 101; e++) begin
            @(posedge clk); #1;
            if (tone_out_b !== 1'b0) tone_bad++;
            compared++;
            if (done_b !== (e == 101) || playing_b !== (e != 101)) begin
                mismatched++;
                $display("FAIL nogap_timing: edge %0d done=%b playing=%b, required %b/%b",
                         e, done_b, playing_b, e == 101, e != 101);
            end
        end
        compared++;
        if (tone_bad != 0) begin
            mismatched++;
            $display("FAIL nogap_tone: tone_out high on %0d cycles, required 0", tone_bad);
        end
        @(posedge clk); #1;
        compared++;
        if (playing_b !== 1'b1 || done_b !== 1'b0) begin
            mismatched++;
            $display("FAIL back_to_back: playing=%b done=%b, required 1/0", playing_b, done_b);
        end
        play_b = 1'b0;
        stop_b = 1'b1;
        @(posedge clk); #1;
        stop_b = 1'b0;
        compared++;
        if (playing_b !== 1'b0 || done_b !== 1'b0) begin
            mismatched++;
            $display("FAIL nogap_stop: playing=%b done=%b, required 0/0", playing_b, done_b);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i]   = 6'd0;
            ram_b[i] = 6'd0;
        end
        #1;
        test_reset();
        test_sequence();
        test_zero_notes();
        test_lower_inote();
        test_loop_stop();
        test_play_stop();
        test_reset_mid_play();
        test_no_gap_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
